// File: rtl/ddr_burst_arbiter.sv
// Purpose: issues one-cycle wr_trig/rd_trig burst requests to the AXI master, one burst at a time, round-robin between write and read.
// Latency: a trig is registered one cycle after a request is seen in IDLE. Trigs are spaced at least 2 cycles apart.
// Backpressure: only one burst may be outstanding. The WAIT state holds until a done pulse, a vsync read abort, or the watchdog (DDR_ARB_WDT_EN).
module ddr_burst_arbiter #(
  parameter int BURST_LEN    = 16,
  parameter int CNT_W        = 10,
  parameter int RD_THRESH    = 480,
  parameter int FRAME_BURSTS = 16200,
  parameter int FB_W         = 14,
  parameter int TIMEOUT      = 4096
) (
  input  logic             sclk,
  input  logic             s_rst_n,
  input  logic [CNT_W-1:0] wfifo_rd_cnt,
  input  logic [CNT_W-1:0] rfifo_wr_cnt,
  input  logic             wr_done,
  input  logic             rd_done,
  input  logic             vga_vsync,
  output logic             wr_trig,
  output logic             rd_trig,
  output logic             busy,
  output logic             frame_valid,
  output logic             timeout_err
);

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;

  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            wr_trig_q, wr_trig_d;
  logic            rd_trig_q, rd_trig_d;
  logic            busy_q, busy_d;
  logic            frame_valid_q, frame_valid_d;
  logic [FB_W-1:0] fb_cnt_q, fb_cnt_d;
  logic            vs_meta_q, vs_s_q;
  logic            wr_req, rd_req;
  logic            wdt_expire;

  // Bring the display vsync into the sclk domain.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      vs_meta_q <= 1'b0;
      vs_s_q    <= 1'b0;
    end else begin
      vs_meta_q <= vga_vsync;
      vs_s_q    <= vs_meta_q;
    end
  end

  // Reads are held off until a full frame exists in DDR and outside vsync.
  always_comb begin
    wr_req = (wfifo_rd_cnt >= CNT_W'(BURST_LEN));
    rd_req = frame_valid_q & ~vs_s_q & (rfifo_wr_cnt <= CNT_W'(RD_THRESH));
  end

`ifdef DDR_ARB_WDT_EN
  localparam int WDT_W = $clog2(TIMEOUT);

  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  // Watchdog counts cycles spent in a WAIT state and restarts on every state entry.
  always_comb begin
    wdt_cnt_d = '0;
    if ((state_q != IDLE) && (state_d == state_q)) begin
      wdt_cnt_d = wdt_cnt_q + 1'b1;
    end
    // A timeout is flagged only when the burst did not end by itself on that cycle.
    timeout_err_d = timeout_err_q |
                    (wdt_expire &
                     ~(((state_q == WR_WAIT) & wr_done) |
                       ((state_q == RD_WAIT) & (rd_done | vs_s_q))));
  end

  // Watchdog state.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      wdt_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wdt_cnt_q     <= wdt_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign wdt_expire  = (wdt_cnt_q == WDT_W'(TIMEOUT - 1));
  assign timeout_err = timeout_err_q;
`else
  // Without the watchdog a WAIT state holds until its done pulse; the compare below is never true.
  assign wdt_expire  = (TIMEOUT < 0);
  assign timeout_err = 1'b0;
`endif

  // Next-state logic: round-robin grant in IDLE, completion tracking in WAIT.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    wr_trig_d     = 1'b0;
    rd_trig_d     = 1'b0;
    fb_cnt_d      = fb_cnt_q;
    frame_valid_d = frame_valid_q;
    case (state_q)
      IDLE: begin
        if (wr_req && (!rd_req || (last_grant_q == GRANT_RD))) begin
          state_d      = WR_WAIT;
          last_grant_d = GRANT_WR;
          wr_trig_d    = 1'b1;
        end else if (rd_req) begin
          state_d      = RD_WAIT;
          last_grant_d = GRANT_RD;
          rd_trig_d    = 1'b1;
        end
      end
      WR_WAIT: begin
        if (wr_done) begin
          state_d = IDLE;
          if (fb_cnt_q == FB_W'(FRAME_BURSTS - 1)) begin
            fb_cnt_d      = '0;
            frame_valid_d = 1'b1;
          end else begin
            fb_cnt_d = fb_cnt_q + 1'b1;
          end
        end else if (wdt_expire) begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        // The master drops its read on vsync, so vsync ends the burst as well.
        if (rd_done || vs_s_q || wdt_expire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM and registered outputs.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= GRANT_RD;
      wr_trig_q     <= 1'b0;
      rd_trig_q     <= 1'b0;
      busy_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      fb_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      wr_trig_q     <= wr_trig_d;
      rd_trig_q     <= rd_trig_d;
      busy_q        <= busy_d;
      frame_valid_q <= frame_valid_d;
      fb_cnt_q      <= fb_cnt_d;
    end
  end

  assign wr_trig     = wr_trig_q;
  assign rd_trig     = rd_trig_q;
  assign busy        = busy_q;
  assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Directed bench for ddr_burst_arbiter, with the frame length shortened to 4 bursts and the watchdog timeout set to 64.
// Expected trig kinds are queued when stimulus is driven; a negedge monitor pops the queue and compares each trig as it appears.
// Watchdog expectations follow DDR_ARB_WDT_EN.
module tb_ddr_burst_arbiter;
  localparam int CNT_W = 10;
  localparam int FB    = 4;
  localparam int TO    = 64;
  localparam logic [1:0] EXP_WR = 2'b01;
  localparam logic [1:0] EXP_RD = 2'b10;

  logic             sclk;
  logic             s_rst_n;
  logic [CNT_W-1:0] wfifo_rd_cnt;
  logic [CNT_W-1:0] rfifo_wr_cnt;
  logic             wr_done, rd_done, vga_vsync;
  logic             wr_trig, rd_trig, busy, frame_valid, timeout_err;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] sb[$];
  int         exp_fb = 0;
  logic       exp_fv = 1'b0;
  int         gap = 100;
  bit         seen_trig = 0;
  logic       got_rd;

  ddr_burst_arbiter #(
    .BURST_LEN(16), .CNT_W(CNT_W), .RD_THRESH(480),
    .FRAME_BURSTS(FB), .FB_W(14), .TIMEOUT(TO)
  ) dut (
    .sclk(sclk), .s_rst_n(s_rst_n),
    .wfifo_rd_cnt(wfifo_rd_cnt), .rfifo_wr_cnt(rfifo_wr_cnt),
    .wr_done(wr_done), .rd_done(rd_done), .vga_vsync(vga_vsync),
    .wr_trig(wr_trig), .rd_trig(rd_trig), .busy(busy),
    .frame_valid(frame_valid), .timeout_err(timeout_err)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic wait_trig(input int budget, output logic is_rd);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (wr_trig || rd_trig) break;
    end
    check("trig_within_budget", {31'd0, wr_trig | rd_trig}, 32'd1);
    is_rd = rd_trig;
  endtask

  // wr_done while the DUT is in WR_WAIT; advances the frame model.
  task automatic pulse_wr_done();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    exp_fb = (exp_fb + 1) % FB;
    if (exp_fb == 0) exp_fv = 1'b1;
  endtask

  task automatic pulse_rd_done();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
  endtask

  task automatic write_burst(input int lat);
    wfifo_rd_cnt = 16;
    sb.push_back(EXP_WR);
    wait_trig(3, got_rd);
    check("wb_is_write", {31'd0, got_rd}, 32'd0);
    wfifo_rd_cnt = 0;
    repeat (lat) tick();
    pulse_wr_done();
    check("wb_busy_clear", {31'd0, busy}, 32'd0);
  endtask

  // Scoreboard monitor: every trig must match the oldest queued expectation and respect spacing.
  always @(negedge sclk) begin
    if (wr_trig || rd_trig) begin
      if (sb.size() == 0) check("trig_unexpected", {30'd0, rd_trig, wr_trig}, 32'd0);
      else check("trig_kind", {30'd0, rd_trig, wr_trig}, {30'd0, sb.pop_front()});
      if (seen_trig) check("trig_spacing", {31'd0, gap >= 1}, 32'd1);
      gap = 0;
      seen_trig = 1;
    end else if (gap < 100) begin
      gap++;
    end
  end

  initial begin
    s_rst_n = 1'b0; wfifo_rd_cnt = 0; rfifo_wr_cnt = 0;
    wr_done = 1'b0; rd_done = 1'b0; vga_vsync = 1'b0;
    repeat (3) tick();
    check("rst_wr_trig", {31'd0, wr_trig}, 32'd0);
    check("rst_rd_trig", {31'd0, rd_trig}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);

    // First write burst right after reset release.
    wfifo_rd_cnt = 16;
    sb.push_back(EXP_WR);
    s_rst_n = 1'b1;
    tick();
    check("first_wr_trig", {31'd0, wr_trig}, 32'd1);
    check("first_busy", {31'd0, busy}, 32'd1);
    wfifo_rd_cnt = 0;
    tick();
    check("wr_trig_one_cycle", {31'd0, wr_trig}, 32'd0);
    check("busy_held", {31'd0, busy}, 32'd1);
    repeat (18) tick();
    pulse_wr_done();
    check("busy_after_done", {31'd0, busy}, 32'd0);

    // Complete the shortened frame.
    rfifo_wr_cnt = 1023;
    write_burst(2);
    write_burst(3);
    check("fv_before_frame", {31'd0, frame_valid}, {31'd0, exp_fv});
    write_burst(4);
    check("fv_after_frame", {31'd0, frame_valid}, {31'd0, exp_fv});
    check("fb_wrapped", {18'd0, dut.fb_cnt_q}, exp_fb);

    // Both sides requesting: last grant was write, so read goes first.
    wfifo_rd_cnt = 32;
    rfifo_wr_cnt = 100;
    sb.push_back(EXP_RD); sb.push_back(EXP_WR);
    sb.push_back(EXP_RD); sb.push_back(EXP_WR);
    for (int i = 0; i < 4; i++) begin
      wait_trig(4, got_rd);
      check("alt_order", {31'd0, got_rd}, (i % 2 == 0) ? 32'd1 : 32'd0);
      repeat (4) tick();
      if (i == 3) begin
        wfifo_rd_cnt = 0;
        rfifo_wr_cnt = 1023;
      end
      if (got_rd) pulse_rd_done();
      else pulse_wr_done();
    end
    check("alt_idle", {31'd0, busy}, 32'd0);

    // Vsync aborts an outstanding read; a pending write is still granted.
    rfifo_wr_cnt = 100;
    sb.push_back(EXP_RD);
    wait_trig(4, got_rd);
    wfifo_rd_cnt = 16;
    vga_vsync = 1'b1;
    sb.push_back(EXP_WR);
    tick();
    tick();
    check("rd_wait_pre_abort", {31'd0, busy}, 32'd1);
    tick();
    check("vsync_abort", {31'd0, busy}, 32'd0);
    tick();
    check("wr_during_vsync", {31'd0, wr_trig}, 32'd1);
    wfifo_rd_cnt = 0;
    tick();
    check("wr_wait_ignores_vs", {31'd0, busy}, 32'd1);
    pulse_wr_done();
    repeat (3) tick();
    check("no_rd_in_vsync", {31'd0, busy}, 32'd0);
    vga_vsync = 1'b0;
    sb.push_back(EXP_RD);
    wait_trig(6, got_rd);
    rfifo_wr_cnt = 1023;
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check("wr_done_ignored_rd", {31'd0, busy}, 32'd1);
    check("fb_not_bumped", {18'd0, dut.fb_cnt_q}, exp_fb);
    pulse_rd_done();
    check("rd_done_idle", {31'd0, busy}, 32'd0);

    // Read threshold boundary.
    rfifo_wr_cnt = 481;
    repeat (6) tick();
    check("no_rd_at_481", {31'd0, busy}, 32'd0);
    rfifo_wr_cnt = 480;
    sb.push_back(EXP_RD);
    wait_trig(3, got_rd);
    check("rd_at_480", {31'd0, got_rd}, 32'd1);
    rfifo_wr_cnt = 1023;
    pulse_rd_done();

    // Write burst with no completion.
    wfifo_rd_cnt = 16;
    sb.push_back(EXP_WR);
    wait_trig(3, got_rd);
    wfifo_rd_cnt = 0;
`ifdef DDR_ARB_WDT_EN
    repeat (63) tick();
    check("wdt_not_yet", {31'd0, busy}, 32'd1);
    tick();
    check("wdt_busy_drop", {31'd0, busy}, 32'd0);
    check("wdt_err_set", {31'd0, timeout_err}, 32'd1);
    check("wdt_fb_unchanged", {18'd0, dut.fb_cnt_q}, exp_fb);
    repeat (5) tick();
    check("wdt_err_sticky", {31'd0, timeout_err}, 32'd1);
`else
    repeat (100) tick();
    check("wait_holds", {31'd0, busy}, 32'd1);
    check("no_timeout_err", {31'd0, timeout_err}, 32'd0);
    pulse_wr_done();
    check("late_done_idle", {31'd0, busy}, 32'd0);
    check("late_done_fb", {18'd0, dut.fb_cnt_q}, exp_fb);
`endif

    // Reset in the middle of a burst.
    wfifo_rd_cnt = 16;
    sb.push_back(EXP_WR);
    wait_trig(3, got_rd);
    wfifo_rd_cnt = 0;
    @(negedge sclk);
    #1;
    s_rst_n = 1'b0;
    #1;
    exp_fb = 0;
    exp_fv = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_fv", {31'd0, frame_valid}, {31'd0, exp_fv});
    check("mid_rst_fb", {18'd0, dut.fb_cnt_q}, exp_fb);
    check("mid_rst_err", {31'd0, timeout_err}, 32'd0);
    repeat (2) tick();
    s_rst_n = 1'b1;
    repeat (5) tick();
    check("no_reissue", {31'd0, busy}, 32'd0);

    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
